branch_cond_unit: RTL and testbench
===================================

// Module: branch_cond_unit
// PURPOSE
// - Consumer end of the ALU flag interface: latches N/Z/V/C from flag-setting ops (ADDS/SUBS/ANDS),
//   evaluates LEGv8/ARM B.cond conditions against them, and returns a registered taken/target result.
// - Sits between the execute-stage ALU and fetch/PC-select; one request in flight per stage, valid/ready both sides.
// PARAMETERS
// - ADDR_W   64  width of branch target / fall-through addresses
// - TAG_W    4   opaque request tag, returned unchanged with the result
// PORTS
// - clk          in   1       single clock, rising edge
// - reset        in   1       synchronous, active-high
// - flag_we      in   1       write flags this cycle (flag-setting instruction retires from ALU)
// - N_in,Z_in    in   1 each  ALU negative / zero flags
// - V_in,C_in    in   1 each  ALU overflow / carry-out flags (C=1 means no borrow on subtract)
// - req_valid    in   1       branch request present
// - req_ready    out  1       unit can accept a request this cycle
// - req_cond     in   4       ARM condition code
// - req_target   in   ADDR_W  taken target
// - req_fallthru in   ADDR_W  not-taken PC (PC+4)
// - req_tag      in   TAG_W   request tag
// - res_valid    out  1       result present
// - res_ready    in   1       downstream accepts result
// - res_taken    out  1       condition true
// - res_pc       out  ADDR_W  res_taken ? target : fallthru
// - res_tag      out  TAG_W   echoed tag
// - nzcv         out  4       architectural flag register {N,Z,C,V}
// BEHAVIOUR
// - Reset: nzcv=4'b0100 (Z=1), res_valid=0, res_taken=0, res_pc=0, res_tag=0, skid empty, req_ready=1 the cycle after.
// - Flag register: on flag_we, nzcv <= {N_in,Z_in,C_in,V_in} at next edge; otherwise holds. reset wins over flag_we.
// - Bypass: request accepted (req_valid&req_ready) in a cycle with flag_we evaluates against the NEW flags.
// - Latency: accepted request -> res_valid exactly 1 cycle later when output stage free; result fully registered.
// - Conditions: 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z;
//   9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 1 (ARM: always).
// - Output handshake: res_* stable while res_valid&!res_ready; transfer on res_valid&res_ready.
// - Buffering: output register + one-entry skid buffer. req_ready = skid empty (registered, no comb path from res_ready).
//   Request accepted while output stalled -> goes to skid; skid drains to output on next transfer.
//   Simultaneous accept + output transfer with skid empty -> new result replaces output, no bubble.
// - Full: output and skid both occupied -> req_ready=0; req_valid ignored, flags still update.
// - Evaluation happens at acceptance; later flag_we never alters a queued result.
// - reset mid-operation: both entries dropped, no result emitted for in-flight requests.
// - Throughput: 1 result/cycle sustained when res_ready=1.
// STRUCTURE
// - Shared package: condition-code localparams (COND_EQ..COND_NV), NZCV bit indices.
// - Sub-module cond_eval: combinational (cond[3:0], n,z,c,v) -> taken; reused by verifier's model.
// - Top holds nzcv register, bypass mux, output register, skid buffer.
// TESTING
// - Reset: assert reset 2 cycles with flag_we=1 -> nzcv=4'b0100, res_valid=0; req_ready=1 after release.
// - Bypass: flag_we with Z_in=1 plus req cond=0(EQ) target=64'h100 same cycle -> next cycle res_taken=1, res_pc=64'h100.
// - Full sweep: all 16 conds x 16 NZCV values -> res_taken matches table; res_pc selects target/fallthru.
// - Signed compare: flags from SUBS 5-7 (N=1,Z=0,C=0,V=0) -> LT=1, GE=0, LO=1, HI=0, LE=1.
// - Backpressure: res_ready=0 for 3 cycles, 3 back-to-back reqs tags 1,2,3 -> tag3 held (req_ready=0);
//   release -> results tag1, tag2 in order, no loss/dup, taken bits reflect flags at each acceptance.
// - Reset mid-stall: output+skid full, pulse reset -> res_valid=0 next cycle, neither tag ever emitted.

Source files
------------

// File: rtl/branch_cond_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_pkg
// Shared definitions for the branch condition unit:
//   - ARM/LEGv8 B.cond condition-code encodings (COND_EQ .. COND_NV)
//   - bit positions of N/Z/C/V inside the architectural nzcv register
//   - nzcv reset value and a helper that packs individual ALU flags
// -----------------------------------------------------------------------------
package branch_cond_unit_pkg;

  typedef logic [3:0] cond_t;
  typedef logic [3:0] nzcv_t;

  localparam cond_t COND_EQ = 4'd0;
  localparam cond_t COND_NE = 4'd1;
  localparam cond_t COND_HS = 4'd2;
  localparam cond_t COND_LO = 4'd3;
  localparam cond_t COND_MI = 4'd4;
  localparam cond_t COND_PL = 4'd5;
  localparam cond_t COND_VS = 4'd6;
  localparam cond_t COND_VC = 4'd7;
  localparam cond_t COND_HI = 4'd8;
  localparam cond_t COND_LS = 4'd9;
  localparam cond_t COND_GE = 4'd10;
  localparam cond_t COND_LT = 4'd11;
  localparam cond_t COND_GT = 4'd12;
  localparam cond_t COND_LE = 4'd13;
  localparam cond_t COND_AL = 4'd14;
  localparam cond_t COND_NV = 4'd15;

  // nzcv register layout is {N,Z,C,V}
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // Z=1 out of reset so the register looks like the result of a zero compare
  localparam nzcv_t NZCV_RESET = 4'b0100;

  function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                      input logic c, input logic v);
    nzcv_t f;
    f         = '0;
    f[NZCV_N] = n;
    f[NZCV_Z] = z;
    f[NZCV_C] = c;
    f[NZCV_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/branch_cond_unit_if.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_if
// Bundles the ALU flag write port, the branch request channel and the
// branch result channel of branch_cond_unit.
//   flag_we, N_in, Z_in, V_in, C_in       : flag write from the ALU
//   req_valid/req_ready, req_cond,
//   req_target, req_fallthru, req_tag     : branch request (valid/ready)
//   res_valid/res_ready, res_taken,
//   res_pc, res_tag                       : branch result (valid/ready)
//   nzcv                                  : architectural flags {N,Z,C,V}
// master = producer of flags/requests and consumer of results (pipeline side)
// slave  = the branch condition unit itself
// -----------------------------------------------------------------------------
interface branch_cond_unit_if #(
  parameter int ADDR_W = 64,
  parameter int TAG_W  = 4
);
  logic              flag_we;
  logic              N_in;
  logic              Z_in;
  logic              V_in;
  logic              C_in;

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cond;
  logic [ADDR_W-1:0] req_target;
  logic [ADDR_W-1:0] req_fallthru;
  logic [TAG_W-1:0]  req_tag;

  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic [ADDR_W-1:0] res_pc;
  logic [TAG_W-1:0]  res_tag;

  logic [3:0]        nzcv;

  modport master (
    output flag_we, N_in, Z_in, V_in, C_in,
    output req_valid, req_cond, req_target, req_fallthru, req_tag,
    input  req_ready,
    input  res_valid, res_taken, res_pc, res_tag,
    output res_ready,
    input  nzcv
  );

  modport slave (
    input  flag_we, N_in, Z_in, V_in, C_in,
    input  req_valid, req_cond, req_target, req_fallthru, req_tag,
    output req_ready,
    output res_valid, res_taken, res_pc, res_tag,
    input  res_ready,
    output nzcv
  );
endinterface

// File: rtl/branch_cond_unit_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_cond_eval
// Purely combinational B.cond evaluator.
//   i_cond  : 4-bit ARM condition code
//   i_nzcv  : flags {N,Z,C,V}
//   o_taken : 1 when the condition holds (AL and NV are both "always")
// -----------------------------------------------------------------------------
module branch_cond_unit_cond_eval
  import branch_cond_unit_pkg::*;
(
  input  cond_t i_cond,
  input  nzcv_t i_nzcv,
  output logic  o_taken
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_nzcv[NZCV_N];
  assign w_z = i_nzcv[NZCV_Z];
  assign w_c = i_nzcv[NZCV_C];
  assign w_v = i_nzcv[NZCV_V];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = ~w_z;
      COND_HS: o_taken = w_c;
      COND_LO: o_taken = ~w_c;
      COND_MI: o_taken = w_n;
      COND_PL: o_taken = ~w_n;
      COND_VS: o_taken = w_v;
      COND_VC: o_taken = ~w_v;
      COND_HI: o_taken = w_c & ~w_z;
      COND_LS: o_taken = ~w_c | w_z;
      COND_GE: o_taken = (w_n == w_v);
      COND_LT: o_taken = (w_n != w_v);
      COND_GT: o_taken = ~w_z & (w_n == w_v);
      COND_LE: o_taken = w_z | (w_n != w_v);
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit
// Consumer end of the ALU flag interface. Holds the architectural NZCV
// register, evaluates B.cond conditions for incoming branch requests and
// returns a fully registered taken/target result.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears flags to Z=1 and drops all
//           queued results
//   bus   : branch_cond_unit_if.slave (flag write, request and result
//           channels, nzcv readback)
// Buffering is an output register plus a one-entry skid buffer, so
// req_ready depends only on registered state (skid empty) and never on
// res_ready combinationally.
// -----------------------------------------------------------------------------
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_cond_unit_if.slave    bus
);

  nzcv_t             r_nzcv;

  // stage p0: flag bypass and condition evaluation at acceptance
  nzcv_t             w_nzcv_p0;
  logic              w_taken_p0;
  logic [ADDR_W-1:0] w_pc_p0;
  logic              w_accept_p0;

  // stage p1: output register and skid buffer
  logic              r_out_vld_p1;
  logic              r_out_taken_p1;
  logic [ADDR_W-1:0] r_out_pc_p1;
  logic [TAG_W-1:0]  r_out_tag_p1;

  logic              r_skid_vld_p1;
  logic              r_skid_taken_p1;
  logic [ADDR_W-1:0] r_skid_pc_p1;
  logic [TAG_W-1:0]  r_skid_tag_p1;

  logic              w_req_ready;
  logic              w_out_free;

  // A request accepted alongside a flag write sees the flags being written.
  assign w_nzcv_p0 = bus.flag_we ? pack_nzcv(bus.N_in, bus.Z_in, bus.C_in, bus.V_in)
                                 : r_nzcv;

  branch_cond_unit_cond_eval u_cond_eval (
    .i_cond  (bus.req_cond),
    .i_nzcv  (w_nzcv_p0),
    .o_taken (w_taken_p0)
  );

  assign w_pc_p0     = w_taken_p0 ? bus.req_target : bus.req_fallthru;
  assign w_req_ready = ~r_skid_vld_p1;
  assign w_accept_p0 = bus.req_valid & w_req_ready;

  // Output slot can take new data when it is empty or being drained this cycle.
  assign w_out_free  = ~r_out_vld_p1 | bus.res_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nzcv         <= NZCV_RESET;
      r_out_vld_p1   <= 1'b0;
      r_out_taken_p1 <= 1'b0;
      r_out_pc_p1    <= '0;
      r_out_tag_p1   <= '0;
      r_skid_vld_p1  <= 1'b0;
    end else begin
      if (bus.flag_we) begin
        r_nzcv <= w_nzcv_p0;
      end

      if (w_out_free) begin
        // Skid has priority: it holds the older result. When it is full,
        // req_ready is low so no new request can compete for the slot.
        if (r_skid_vld_p1) begin
          r_out_vld_p1   <= 1'b1;
          r_out_taken_p1 <= r_skid_taken_p1;
          r_out_pc_p1    <= r_skid_pc_p1;
          r_out_tag_p1   <= r_skid_tag_p1;
          r_skid_vld_p1  <= 1'b0;
        end else if (w_accept_p0) begin
          r_out_vld_p1   <= 1'b1;
          r_out_taken_p1 <= w_taken_p0;
          r_out_pc_p1    <= w_pc_p0;
          r_out_tag_p1   <= bus.req_tag;
        end else begin
          r_out_vld_p1   <= 1'b0;
        end
      end else if (w_accept_p0) begin
        r_skid_vld_p1 <= 1'b1;
      end
    end
  end

  // Skid payload needs no reset; it is qualified by r_skid_vld_p1.
  always_ff @(posedge clk) begin
    if (!w_out_free && w_accept_p0) begin
      r_skid_taken_p1 <= w_taken_p0;
      r_skid_pc_p1    <= w_pc_p0;
      r_skid_tag_p1   <= bus.req_tag;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.res_valid = r_out_vld_p1;
  assign bus.res_taken = r_out_taken_p1;
  assign bus.res_pc    = r_out_pc_p1;
  assign bus.res_tag   = r_out_tag_p1;
  assign bus.nzcv      = r_nzcv;

endmodule

// File: tb/tb_branch_cond_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_cond_unit
// Directed bench for branch_cond_unit: reset, flag bypass, full cond x NZCV
// sweep, signed-compare flags, backpressure through the skid buffer and
// reset while stalled.
// -----------------------------------------------------------------------------
module tb_branch_cond_unit;

  localparam int ADDR_W = 64;
  localparam int TAG_W  = 4;

  logic clk;
  logic reset;

  int n_checks;
  int n_errors;

  branch_cond_unit_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  branch_cond_unit #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference from the ARM ConditionHolds pseudocode: base test on cond[3:1],
  // inverted by cond[0] except for 4'b1111.
  function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'b000:  r = z;
      3'b001:  r = c;
      3'b010:  r = n;
      3'b011:  r = v;
      3'b100:  r = c && !z;
      3'b101:  r = (n == v);
      3'b110:  r = (n == v) && !z;
      default: r = 1'b1;
    endcase
    if (cond[0] && cond != 4'b1111) r = !r;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic we, input logic [3:0] f);
    bus.flag_we = we;
    bus.N_in    = f[3];
    bus.Z_in    = f[2];
    bus.C_in    = f[1];
    bus.V_in    = f[0];
  endtask

  task automatic set_req(input logic vld, input logic [3:0] cond,
                         input logic [63:0] tgt, input logic [63:0] fall,
                         input logic [3:0] tag);
    bus.req_valid    = vld;
    bus.req_cond     = cond;
    bus.req_target   = tgt;
    bus.req_fallthru = fall;
    bus.req_tag      = tag;
  endtask

  initial begin
    logic [63:0] tgt;
    logic [63:0] fall;
    n_checks = 0;
    n_errors = 0;

    // Reset held 2 cycles with a flag write pending: reset must win.
    reset = 1'b1;
    set_flags(1'b1, 4'b1011);
    set_req(1'b0, 4'd0, 64'h0, 64'h0, 4'h0);
    bus.res_ready = 1'b1;
    tick();
    tick();
    chk("rst nzcv", bus.nzcv, 4'b0100);
    chk("rst res_valid", bus.res_valid, 1'b0);
    chk("rst res_taken", bus.res_taken, 1'b0);
    chk("rst res_pc", bus.res_pc, 64'h0);
    chk("rst res_tag", bus.res_tag, 4'h0);
    reset = 1'b0;
    set_flags(1'b0, 4'b0000);
    tick();
    chk("post-rst req_ready", bus.req_ready, 1'b1);
    chk("post-rst nzcv hold", bus.nzcv, 4'b0100);

    // Clear flags, then EQ without bypass must be not taken.
    set_flags(1'b1, 4'b0000);
    tick();
    set_flags(1'b0, 4'b0000);
    chk("flags cleared", bus.nzcv, 4'b0000);
    set_req(1'b1, 4'd0, 64'h200, 64'h204, 4'h1);
    tick();
    chk("EQ Z=0 valid", bus.res_valid, 1'b1);
    chk("EQ Z=0 taken", bus.res_taken, 1'b0);
    chk("EQ Z=0 pc", bus.res_pc, 64'h204);
    chk("EQ Z=0 tag", bus.res_tag, 4'h1);

    // Bypass: flag write Z=1 in the same cycle as the EQ request.
    set_flags(1'b1, 4'b0100);
    set_req(1'b1, 4'd0, 64'h100, 64'h104, 4'h5);
    tick();
    chk("bypass valid", bus.res_valid, 1'b1);
    chk("bypass taken", bus.res_taken, 1'b1);
    chk("bypass pc", bus.res_pc, 64'h100);
    chk("bypass tag", bus.res_tag, 4'h5);
    chk("bypass nzcv", bus.nzcv, 4'b0100);

    // Full sweep, one request per cycle with flags bypassed in.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        tgt  = 64'hA000_0000_0000_0000 | (64'(f) << 8) | (64'(c) << 4);
        fall = 64'h0000_0000_0000_1000 | (64'(f) << 8) | (64'(c) << 4);
        set_flags(1'b1, 4'(f));
        set_req(1'b1, 4'(c), tgt, fall, 4'(c));
        tick();
        chk($sformatf("sweep f=%0h c=%0d taken", f, c), bus.res_taken, cond_ref(4'(c), 4'(f)));
        chk($sformatf("sweep f=%0h c=%0d pc", f, c), bus.res_pc,
            cond_ref(4'(c), 4'(f)) ? tgt : fall);
        chk($sformatf("sweep f=%0h c=%0d valid", f, c), bus.res_valid, 1'b1);
      end
    end
    set_req(1'b0, 4'd0, 64'h0, 64'h0, 4'h0);

    // Flags from SUBS 5-7: N=1 Z=0 C=0 V=0, then conditions evaluated without bypass.
    set_flags(1'b1, 4'b1000);
    tick();
    set_flags(1'b0, 4'b0000);
    chk("subs nzcv", bus.nzcv, 4'b1000);
    chk("subs drained", bus.res_valid, 1'b0);
    set_req(1'b1, 4'd11, 64'h50, 64'h54, 4'h2);
    tick();
    chk("subs LT", bus.res_taken, 1'b1);
    set_req(1'b1, 4'd10, 64'h50, 64'h54, 4'h2);
    tick();
    chk("subs GE", bus.res_taken, 1'b0);
    chk("subs GE pc", bus.res_pc, 64'h54);
    set_req(1'b1, 4'd3, 64'h50, 64'h54, 4'h2);
    tick();
    chk("subs LO", bus.res_taken, 1'b1);
    set_req(1'b1, 4'd8, 64'h50, 64'h54, 4'h2);
    tick();
    chk("subs HI", bus.res_taken, 1'b0);
    set_req(1'b1, 4'd13, 64'h50, 64'h54, 4'h2);
    tick();
    chk("subs LE", bus.res_taken, 1'b1);
    set_req(1'b0, 4'd0, 64'h0, 64'h0, 4'h0);
    tick();
    chk("subs idle", bus.res_valid, 1'b0);

    // Backpressure: 3 stalled cycles, requests tag1 (MI), tag2 (MI, bypass N=0), tag3 held.
    bus.res_ready = 1'b0;
    set_req(1'b1, 4'd4, 64'h1000, 64'h1004, 4'h1);
    tick();
    chk("bp1 valid", bus.res_valid, 1'b1);
    chk("bp1 tag", bus.res_tag, 4'h1);
    chk("bp1 taken", bus.res_taken, 1'b1);
    chk("bp1 req_ready", bus.req_ready, 1'b1);
    set_flags(1'b1, 4'b0000);
    set_req(1'b1, 4'd4, 64'h2000, 64'h2004, 4'h2);
    tick();
    chk("bp2 tag stable", bus.res_tag, 4'h1);
    chk("bp2 pc stable", bus.res_pc, 64'h1000);
    chk("bp2 req_ready", bus.req_ready, 1'b0);
    chk("bp2 nzcv", bus.nzcv, 4'b0000);
    set_flags(1'b1, 4'b1100);
    set_req(1'b1, 4'd0, 64'h3000, 64'h3004, 4'h3);
    tick();
    set_flags(1'b0, 4'b0000);
    chk("bp3 nzcv", bus.nzcv, 4'b1100);
    chk("bp3 req_ready", bus.req_ready, 1'b0);
    chk("bp3 tag stable", bus.res_tag, 4'h1);
    chk("bp3 taken stable", bus.res_taken, 1'b1);
    bus.res_ready = 1'b1;
    tick();
    chk("bp4 valid", bus.res_valid, 1'b1);
    chk("bp4 tag", bus.res_tag, 4'h2);
    chk("bp4 taken", bus.res_taken, 1'b0);
    chk("bp4 pc", bus.res_pc, 64'h2004);
    chk("bp4 req_ready", bus.req_ready, 1'b1);
    tick();
    set_req(1'b0, 4'd0, 64'h0, 64'h0, 4'h0);
    chk("bp5 valid", bus.res_valid, 1'b1);
    chk("bp5 tag", bus.res_tag, 4'h3);
    chk("bp5 taken", bus.res_taken, 1'b1);
    chk("bp5 pc", bus.res_pc, 64'h3000);
    tick();
    chk("bp6 no dup", bus.res_valid, 1'b0);

    // Reset while output and skid are both full.
    bus.res_ready = 1'b0;
    set_req(1'b1, 4'd14, 64'h9000, 64'h9004, 4'h9);
    tick();
    set_req(1'b1, 4'd14, 64'hA000, 64'hA004, 4'hA);
    tick();
    set_req(1'b0, 4'd0, 64'h0, 64'h0, 4'h0);
    chk("full req_ready", bus.req_ready, 1'b0);
    chk("full valid", bus.res_valid, 1'b1);
    chk("full tag", bus.res_tag, 4'h9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.res_ready = 1'b1;
    chk("midrst valid", bus.res_valid, 1'b0);
    chk("midrst tag", bus.res_tag, 4'h0);
    chk("midrst nzcv", bus.nzcv, 4'b0100);
    chk("midrst req_ready", bus.req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst drop %0d", i), bus.res_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
